// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared types and constants for the fetch stage.
// Covers the fetch-queue entry layout, the IFU state encoding and the default PC.
package ysyx_22040632_riscv_pkg;

  localparam int          FETCH_ADDR_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [31:0]             inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } ifu_state_t;

  // Fetch addresses are always word aligned; low bits of a target are discarded.
  function automatic logic [FETCH_ADDR_W-1:0] align_word(input logic [FETCH_ADDR_W-1:0] addr);
    return {addr[FETCH_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040632_fetch_queue.sv
// In-order queue of fetched {pc, inst} pairs between the fetch FSM and decode.
// The head entry is read combinationally; flush empties the queue on the clock edge.
module ysyx_22040632_fetch_queue
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rrst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH for free.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch unit: owns the PC, issues single in-flight fetches to instruction memory,
// buffers responses for decode and handles redirect/flush from execute.
module ysyx_22040632_ifu
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int               ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int               FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rrst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic [ADDR_W-1:0] pc2id,
  output logic [31:0]       inst2id,
  output logic              fq_empty
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  ifu_state_t       state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] req_pc_reg;

  fetch_entry_t     push_data;
  fetch_entry_t     head;
  logic [CNT_W-1:0] fq_count;
  logic [CNT_W-1:0] count_next;
  logic             fq_full;
  logic             q_empty;
  logic             push;
  logic             pop;

  // A response is only ever accepted in WAIT; DROP and a same-cycle redirect discard it.
  assign push       = (state_reg == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop        = !id_stall && !q_empty && !redirect_valid;
  assign count_next = fq_count + CNT_W'(push) - CNT_W'(pop);

  assign push_data.pc   = req_pc_reg;
  assign push_data.inst = imem_resp_data;

  ysyx_22040632_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rrst_n    (rrst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fq_count),
    .empty     (q_empty),
    .full      (fq_full)
  );

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= '0;
    end else if (redirect_valid) begin
      // The queue is flushed on this edge, so every exit below has credit to fetch again.
      pc_reg <= align_word(redirect_pc);
      case (state_reg)
        IDLE:    state_reg <= REQ;
        REQ:     state_reg <= imem_req_ready ? DROP : REQ;
        WAIT:    state_reg <= imem_resp_valid ? REQ : DROP;
        DROP:    state_reg <= imem_resp_valid ? REQ : DROP;
        default: state_reg <= IDLE;
      endcase
    end else begin
      case (state_reg)
        IDLE: begin
          if (fq_count < CNT_W'(FQ_DEPTH)) begin
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (imem_req_ready) begin
            req_pc_reg <= pc_reg;
            pc_reg     <= pc_reg + ADDR_W'(4);
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            state_reg <= (count_next < CNT_W'(FQ_DEPTH)) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (imem_resp_valid) begin
            state_reg <= REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_reg == REQ);
  assign imem_req_addr  = pc_reg;
  assign pc2id          = q_empty ? '0 : head.pc;
  assign inst2id        = q_empty ? NOP_INST : head.inst;
  assign fq_empty       = q_empty;

endmodule

// File: tb/tb_ysyx_22040632_ifu.sv
// Directed bench for the fetch stage: a 1-cycle instruction memory model answers each
// accepted request with ~addr, and each scenario task checks its own expectations.
module tb_ysyx_22040632_ifu;
  import ysyx_22040632_riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rrst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] pc2id;
  logic [31:0] inst2id;
  logic        fq_empty;

  logic        mem_auto;
  logic        auto_valid;
  logic [31:0] auto_data;
  logic        man_valid;
  logic [31:0] man_data;
  logic        hs_seen;
  logic [31:0] hs_addr;

  logic [31:0] req_log[$];
  logic [63:0] dec_log[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_resp_valid = mem_auto ? auto_valid : man_valid;
  assign imem_resp_data  = mem_auto ? auto_data  : man_data;

  ysyx_22040632_ifu dut (
    .clk             (clk),
    .rrst_n          (rrst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_stall        (id_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .pc2id           (pc2id),
    .inst2id         (inst2id),
    .fq_empty        (fq_empty)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a;
  endfunction

  // Observe handshakes and decode consumption mid-cycle, away from the active edge.
  always @(negedge clk) begin
    hs_seen = imem_req_valid && imem_req_ready && rrst_n;
    hs_addr = imem_req_addr;
    if (hs_seen) req_log.push_back(imem_req_addr);
    if (rrst_n && !id_stall && !fq_empty && !redirect_valid) begin
      dec_log.push_back({pc2id, inst2id});
      $display("[%0t] decode pc=%h inst=%h", $time, pc2id, inst2id);
    end
  end

  always @(posedge clk) begin
    if (mem_auto) begin
      #1;
      auto_valid = hs_seen;
      auto_data  = inst_of(hs_addr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nonempty(input string tag);
    for (int i = 0; i < 20 && fq_empty; i++) tick();
    n_cmp++;
    if (fq_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: fq_empty=%b after 20 cycles, required 0", tag, fq_empty);
    end
  endtask

  // Park the FSM in REQ with no response owed, then hand the memory to manual control.
  task automatic quiesce;
    imem_req_ready = 1'b0;
    repeat (3) tick();
    man_valid = 1'b0;
    mem_auto  = 1'b0;
  endtask

  task automatic test_reset;
    rrst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid); end
    n_cmp++; if (pc2id !== 32'h0) begin n_bad++; $display("FAIL reset_pc2id: got %h, required 0", pc2id); end
    n_cmp++; if (inst2id !== 32'h0) begin n_bad++; $display("FAIL reset_inst2id: got %h, required 0", inst2id); end
    n_cmp++; if (fq_empty !== 1'b1) begin n_bad++; $display("FAIL reset_fq_empty: got %b, required 1", fq_empty); end
    n_cmp++; if (imem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_addr: got %h, required 80000000", imem_req_addr); end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    mem_auto = 1'b1;
    imem_req_ready = 1'b1;
    req_log.delete();
    dec_log.delete();
    rrst_n = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if (req_log.size() < 5 || dec_log.size() < 5) begin
      n_bad++;
      $display("FAIL seq_progress: reqs=%0d decodes=%0d, required >=5 each", req_log.size(), dec_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        a = 32'h8000_0000 + 32'(4 * i);
        n_cmp++;
        if (req_log[i] !== a) begin n_bad++; $display("FAIL seq_addr%0d: got %h, required %h", i, req_log[i], a); end
        n_cmp++;
        if (dec_log[i] !== {a, inst_of(a)}) begin n_bad++; $display("FAIL seq_decode%0d: got %h, required %h", i, dec_log[i], {a, inst_of(a)}); end
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] a;
    id_stall = 1'b1;
    repeat (6) tick();
    n_cmp++; if (req_log.size() - dec_log.size() !== 2) begin n_bad++; $display("FAIL stall_in_flight: got %0d, required 2", req_log.size() - dec_log.size()); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b, required 0", imem_req_valid); end
    a = 32'h8000_0000 + 32'(4 * dec_log.size());
    n_cmp++; if (pc2id !== a) begin n_bad++; $display("FAIL stall_head_pc: got %h, required %h", pc2id, a); end
    id_stall = 1'b0;
    repeat (12) tick();
    for (int i = 0; i < dec_log.size(); i++) begin
      a = 32'h8000_0000 + 32'(4 * i);
      n_cmp++;
      if (dec_log[i] !== {a, inst_of(a)}) begin n_bad++; $display("FAIL stall_order%0d: got %h, required %h", i, dec_log[i], {a, inst_of(a)}); end
    end
  endtask

  task automatic test_ready_low;
    logic [31:0] a;
    int          n;
    imem_req_ready = 1'b0;
    repeat (2) tick();
    a = 32'h8000_0000 + 32'(4 * req_log.size());
    n = req_log.size();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid%0d: got %b, required 1", i, imem_req_valid); end
      n_cmp++; if (imem_req_addr !== a) begin n_bad++; $display("FAIL hold_addr%0d: got %h, required %h", i, imem_req_addr, a); end
    end
    n_cmp++; if (req_log.size() !== n) begin n_bad++; $display("FAIL hold_no_issue: got %0d reqs, required %0d", req_log.size(), n); end
    imem_req_ready = 1'b1;
    tick();
    n_cmp++; if (req_log.size() !== n + 1 || req_log[req_log.size()-1] !== a) begin n_bad++; $display("FAIL hold_issue: got %0d reqs last %h, required %0d last %h", req_log.size(), req_log[req_log.size()-1], n + 1, a); end
    repeat (4) tick();
  endtask

  task automatic test_redirect_wait;
    quiesce();
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (fq_empty !== 1'b1) begin n_bad++; $display("FAIL rdw_flush: fq_empty=%b, required 1", fq_empty); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_drop_valid: got %b, required 0", imem_req_valid); end
    man_valid = 1'b1;
    man_data  = 32'hDEAD_BEEF;
    tick();
    man_valid = 1'b0;
    n_cmp++; if (fq_empty !== 1'b1) begin n_bad++; $display("FAIL rdw_stale_dropped: fq_empty=%b, required 1", fq_empty); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin n_bad++; $display("FAIL rdw_new_req: valid=%b addr=%h, required 1 80000100", imem_req_valid, imem_req_addr); end
    mem_auto = 1'b1;
    wait_nonempty("rdw");
    n_cmp++; if (pc2id !== 32'h8000_0100 || inst2id !== inst_of(32'h8000_0100)) begin n_bad++; $display("FAIL rdw_first_inst: got %h/%h, required 80000100/%h", pc2id, inst2id, inst_of(32'h8000_0100)); end
    repeat (4) tick();
  endtask

  task automatic test_redirect_resp_and_drop;
    quiesce();
    imem_req_ready = 1'b1;
    tick();
    man_valid      = 1'b1;
    man_data       = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    man_valid      = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++; if (fq_empty !== 1'b1) begin n_bad++; $display("FAIL rdr_resp_discarded: fq_empty=%b, required 1", fq_empty); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin n_bad++; $display("FAIL rdr_req: valid=%b addr=%h, required 1 80000200", imem_req_valid, imem_req_addr); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    tick();
    redirect_pc    = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rdr_drop_hold: valid=%b, required 0", imem_req_valid); end
    man_valid = 1'b1;
    man_data  = 32'h2222_2222;
    tick();
    man_valid = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0400) begin n_bad++; $display("FAIL rdr_latest_target: valid=%b addr=%h, required 1 80000400", imem_req_valid, imem_req_addr); end
    n_cmp++; if (fq_empty !== 1'b1) begin n_bad++; $display("FAIL rdr_one_dropped: fq_empty=%b, required 1", fq_empty); end
    mem_auto = 1'b1;
    wait_nonempty("rdr");
    n_cmp++; if (pc2id !== 32'h8000_0400 || inst2id !== inst_of(32'h8000_0400)) begin n_bad++; $display("FAIL rdr_first_inst: got %h/%h, required 80000400/%h", pc2id, inst2id, inst_of(32'h8000_0400)); end
    repeat (4) tick();
  endtask

  task automatic test_pc_wrap;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    dec_log.delete();
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    n_cmp++;
    if (dec_log.size() < 2) begin
      n_bad++;
      $display("FAIL wrap_progress: decodes=%0d, required >=2", dec_log.size());
    end else begin
      n_cmp++; if (dec_log[0] !== {32'hFFFF_FFFC, 32'h0000_0003}) begin n_bad++; $display("FAIL wrap_first: got %h, required fffffffc00000003", dec_log[0]); end
      n_cmp++; if (dec_log[1] !== {32'h0000_0000, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL wrap_second: got %h, required 00000000ffffffff", dec_log[1]); end
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] q;
    quiesce();
    imem_req_ready = 1'b1;
    id_stall       = 1'b1;
    q = imem_req_addr;
    tick();
    man_valid = 1'b1;
    man_data  = 32'h3333_3333;
    tick();
    man_valid = 1'b0;
    n_cmp++; if (pc2id !== q || inst2id !== 32'h3333_3333) begin n_bad++; $display("FAIL rst_pre_head: got %h/%h, required %h/33333333", pc2id, inst2id, q); end
    tick();
    #2;
    rrst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b, required 0", imem_req_valid); end
    n_cmp++; if (pc2id !== 32'h0 || inst2id !== 32'h0) begin n_bad++; $display("FAIL rst_mid_out: got %h/%h, required 0/0", pc2id, inst2id); end
    n_cmp++; if (fq_empty !== 1'b1) begin n_bad++; $display("FAIL rst_mid_empty: got %b, required 1", fq_empty); end
    tick();
    rrst_n    = 1'b1;
    man_valid = 1'b1;
    man_data  = 32'h4444_4444;
    tick();
    man_valid = 1'b0;
    n_cmp++; if (fq_empty !== 1'b1) begin n_bad++; $display("FAIL rst_stray_ignored: fq_empty=%b, required 1", fq_empty); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_first_req: valid=%b addr=%h, required 1 80000000", imem_req_valid, imem_req_addr); end
    id_stall = 1'b0;
    mem_auto = 1'b1;
    wait_nonempty("rst");
    n_cmp++; if (pc2id !== 32'h8000_0000 || inst2id !== inst_of(32'h8000_0000)) begin n_bad++; $display("FAIL rst_first_inst: got %h/%h, required 80000000/%h", pc2id, inst2id, inst_of(32'h8000_0000)); end
  endtask

  initial begin
    rrst_n         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_stall       = 1'b0;
    imem_req_ready = 1'b0;
    mem_auto       = 1'b0;
    auto_valid     = 1'b0;
    auto_data      = 32'h0;
    man_valid      = 1'b0;
    man_data       = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_ready_low();
    test_redirect_wait();
    test_redirect_resp_and_drop();
    test_pc_wrap();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
